// File: rtl/genie_pkg.sv
// Shared types for the GENIE stream stages (merge/split).
package genie_pkg;

   // Split-stage packet tracking: waiting for a first beat, or inside a packet.
   typedef enum logic [0:0] {
      S_SOP = 1'b0,
      S_PKT = 1'b1
   } genie_split_state_t;

   // Data bus width used when the payload width parameter may be zero.
   function automatic int bus_width(input int width);
      return (width > 0) ? width : 1;
   endfunction

endpackage

// File: rtl/genie_split.sv
// Packet-aware fan-out: routes each packet of one valid/ready/eop stream to
// the outputs selected by a mask taken on the packet's first beat. Multicast
// beats retire only after every selected output has accepted them; outputs
// that already took the current beat are masked off until it retires.
module genie_split
   import genie_pkg::*;
#(
   parameter int NO    = 2,
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_valid,
   input  logic [bus_width(WIDTH)-1:0] i_data,
   input  logic                       i_eop,
   input  logic [NO-1:0]              i_mask,
   output logic                       o_ready,
   output logic [NO-1:0]              o_valid,
   output logic [bus_width(WIDTH)-1:0] o_data,
   output logic                       o_eop,
   input  logic [NO-1:0]              i_ready
);

   localparam int DW = bus_width(WIDTH);

   genie_split_state_t state;
   logic [NO-1:0]      pkt_mask;
   logic [NO-1:0]      done;

   logic [NO-1:0]      eff_mask;
   logic [NO-1:0]      pending;
   logic [NO-1:0]      stall;
   logic [NO-1:0]      accept;
   logic               beat_done;

   // First beat routes by the live mask; later beats by the latched one.
   always_comb begin
      eff_mask = (state == S_SOP) ? i_mask : pkt_mask;
   end

   // Per-output presentation: an output sees the beat only until it takes it.
   for (genvar j = 0; j < NO; j++) begin : g_out
      assign pending[j] = eff_mask[j] & ~done[j];
      assign o_valid[j] = i_valid & pending[j];
      assign stall[j]   = pending[j] & ~i_ready[j];
      assign accept[j]  = o_valid[j] & i_ready[j];
   end

   // The beat retires once no selected output is still holding it back.
   always_comb begin
      o_ready   = ~|stall;
      beat_done = i_valid & o_ready;
   end

   // Payload is broadcast unchanged; a zero-width payload drives a constant.
   if (WIDTH > 0) begin : g_data
      assign o_data = i_data;
   end else begin : g_nodata
      logic unused_data;
      assign unused_data = ^i_data;
      assign o_data      = {DW{1'b0}};
   end

   assign o_eop = i_eop;

   // Packet FSM, latched mask and per-beat delivery record.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_SOP;
         pkt_mask <= '0;
         done     <= '0;
      end else begin
         if (beat_done) begin
            done <= '0;
         end else if (i_valid) begin
            done <= done | accept;
         end

         case (state)
            S_SOP: begin
               if (i_valid) begin
                  pkt_mask <= i_mask;
               end
               if (beat_done && !i_eop) begin
                  state <= S_PKT;
               end
            end
            S_PKT: begin
               if (beat_done && i_eop) begin
                  state <= S_SOP;
               end
            end
            default: state <= S_SOP;
         endcase
      end
   end

endmodule

// File: tb/tb_genie_split.sv
// Self-checking bench for genie_split (NO=4, WIDTH=8): directed scenarios
// followed by randomized packets, all compared against a packet-level model.
module tb_genie_split;

   localparam int NO = 4;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_valid;
   logic [W-1:0]  i_data;
   logic          i_eop;
   logic [NO-1:0] i_mask;
   logic          o_ready;
   logic [NO-1:0] o_valid;
   logic [W-1:0]  o_data;
   logic          o_eop;
   logic [NO-1:0] i_ready;

   int checks   = 0;
   int failures = 0;

   // Model: are we inside a packet, where does it go, who already has the beat.
   logic          m_in_pkt;
   logic [NO-1:0] m_dest;
   logic [NO-1:0] m_have;

   genie_split #(.NO(NO), .WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_valid),
      .i_data  (i_data),
      .i_eop   (i_eop),
      .i_mask  (i_mask),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_data  (o_data),
      .o_eop   (o_eop),
      .i_ready (i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_in_pkt = 1'b0;
      m_dest   = '0;
      m_have   = '0;
   endtask

   // One cycle: drive, compare against the model (and optional hand values),
   // advance the model as the clock edge would, then move to the next cycle.
   task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                       input logic e, input logic [NO-1:0] mk, input logic [NO-1:0] rdy,
                       input logic use_exp, input logic [NO-1:0] exp_v, input logic exp_r,
                       output logic retired);
      logic [NO-1:0] dest, want, ev;
      logic          er;
      i_valid = v; i_data = d; i_eop = e; i_mask = mk; i_ready = rdy;
      #1;
      dest = m_in_pkt ? m_dest : mk;
      want = dest & ~m_have;
      ev   = v ? want : '0;
      er   = ((want & ~rdy) == '0);
      chk({tag, ".o_valid"}, 32'(o_valid), 32'(ev));
      chk({tag, ".o_ready"}, 32'(o_ready), 32'(er));
      chk({tag, ".o_data"},  32'(o_data),  32'(d));
      chk({tag, ".o_eop"},   32'(o_eop),   32'(e));
      if (use_exp) begin
         chk({tag, ".o_valid_hand"}, 32'(o_valid), 32'(exp_v));
         chk({tag, ".o_ready_hand"}, 32'(o_ready), 32'(exp_r));
      end
      retired = v && er;
      if (v) begin
         if (!m_in_pkt) m_dest = mk;
         if (er) begin
            m_have   = '0;
            m_in_pkt = !e;
         end else begin
            m_have = m_have | (ev & rdy);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic r;
      int   len, guard;
      logic [NO-1:0] pmask, mk;
      logic [W-1:0]  d;

      model_reset();
      reset = 1'b1; i_valid = 1'b0; i_data = '0; i_eop = 1'b0; i_mask = '0; i_ready = '0;
      @(negedge clk);
      // Reset state: outputs follow inputs combinationally with nothing delivered.
      i_valid = 1'b1; i_mask = 4'b0101; i_ready = 4'b0001; i_data = 8'h3c; i_eop = 1'b1;
      #1;
      chk("rst.o_valid", 32'(o_valid), 32'h5);
      chk("rst.o_ready", 32'(o_ready), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      i_valid = 1'b0;

      // 1: unicast 3-beat packet, all ready.
      step("t1b0", 1, 8'h11, 0, 4'b0100, 4'hf, 1, 4'b0100, 1, r);
      step("t1b1", 1, 8'h12, 0, 4'b0100, 4'hf, 1, 4'b0100, 1, r);
      step("t1b2", 1, 8'h13, 1, 4'b0100, 4'hf, 1, 4'b0100, 1, r);

      // 2: multicast with one output lagging.
      step("t2c0", 1, 8'h21, 1, 4'b1010, 4'b0010, 1, 4'b1010, 0, r);
      step("t2c1", 1, 8'h21, 1, 4'b1010, 4'b0010, 1, 4'b1000, 0, r);
      step("t2c2", 1, 8'h21, 1, 4'b1010, 4'b0010, 1, 4'b1000, 0, r);
      step("t2c3", 1, 8'h21, 1, 4'b1010, 4'b1010, 1, 4'b1000, 1, r);

      // 3: mask changes mid-packet are ignored; next packet uses new mask.
      step("t3b0", 1, 8'h31, 0, 4'b0100, 4'hf, 1, 4'b0100, 1, r);
      step("t3b1", 1, 8'h32, 0, 4'b0001, 4'hf, 1, 4'b0100, 1, r);
      step("t3b2", 1, 8'h33, 1, 4'b0001, 4'hf, 1, 4'b0100, 1, r);
      step("t3n",  1, 8'h34, 1, 4'b0001, 4'hf, 1, 4'b0001, 1, r);

      // 4: empty mask drops the packet; back to first-beat routing after eop.
      step("t4b0", 1, 8'h41, 0, 4'b0000, 4'h0, 1, 4'b0000, 1, r);
      step("t4b1", 1, 8'h42, 1, 4'b0000, 4'h0, 1, 4'b0000, 1, r);
      step("t4n",  1, 8'h43, 1, 4'b1000, 4'hf, 1, 4'b1000, 1, r);

      // 5: reset mid-packet after a partial delivery.
      step("t5b0", 1, 8'h51, 0, 4'b0110, 4'hf, 1, 4'b0110, 1, r);
      step("t5b1", 1, 8'h52, 0, 4'b0000, 4'b0010, 1, 4'b0110, 0, r);
      reset = 1'b1; i_mask = 4'b1001; i_ready = 4'b0000;
      #1;
      chk("t5rst.o_valid", 32'(o_valid), 32'h9);
      chk("t5rst.o_ready", 32'(o_ready), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step("t5new", 1, 8'h53, 1, 4'b1001, 4'hf, 1, 4'b1001, 1, r);

      // 6: back-to-back single-beat packets.
      step("t6a", 1, 8'h61, 1, 4'b0001, 4'hf, 1, 4'b0001, 1, r);
      step("t6b", 1, 8'h62, 1, 4'b0110, 4'hf, 1, 4'b0110, 1, r);
      step("t6c", 1, 8'h63, 1, 4'b1000, 4'hf, 1, 4'b1000, 1, r);

      // Idle cycle holds everything.
      step("idle", 0, 8'h00, 0, 4'b1111, 4'h0, 1, 4'b0000, 0, r);

      // Randomized packets with random backpressure and idle gaps.
      for (int p = 0; p < 80; p++) begin
         len   = $urandom_range(1, 4);
         pmask = 4'($urandom_range(0, 15));
         for (int b = 0; b < len; b++) begin
            d  = 8'($urandom);
            mk = (b == 0) ? pmask : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
               step("rnd_idle", 0, 8'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                    0, 4'b0, 0, r);
            r = 1'b0;
            guard = 0;
            while (!r && guard < 40) begin
               step("rnd", 1, d, (b == len - 1), mk, 4'($urandom_range(0, 15)), 0, 4'b0, 0, r);
               guard++;
            end
            if (!r) begin
               checks++;
               failures++;
               $error("FAIL rnd_timeout observed=stalled expected=retired");
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
